// File: rtl/calc_sequencer_if.sv
// Calculator operand/result bus plus the LCD req/ack handshake.
// The sequencer drives through the master modport; calculator/LCD side uses slave.
interface calc_sequencer_if;
  logic [2:0]  sel;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        op_sinal_a;
  logic        op_sinal_b;
  logic [15:0] saida;
  logic        sinal_saida;
  logic [15:0] result;
  logic        result_sinal;
  logic        result_valid;
  logic        lcd_req;
  logic        lcd_ack;

  modport master (
    output sel, op_a, op_b, op_sinal_a, op_sinal_b,
    output result, result_sinal, result_valid, lcd_req,
    input  saida, sinal_saida, lcd_ack
  );

  modport slave (
    input  sel, op_a, op_b, op_sinal_a, op_sinal_b,
    input  result, result_sinal, result_valid, lcd_req,
    output saida, sinal_saida, lcd_ack
  );
endinterface

// File: rtl/calc_sequencer.sv
// Control sequencer for the sign-magnitude calculator: button conditioning, power FSM,
// operand latch, fixed-latency wait and LCD handoff. Define CALC_DEBOUNCE_EN for debounce.
module calc_sequencer #(
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned CALC_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic             sinal_a,
  input  logic             sinal_b,
  input  logic             botao_1,
  input  logic             botao_2,
  input  logic             botao_3,
  input  logic             botao_4,
  output logic             power,
  output logic             busy,
  calc_sequencer_if.master bus
);

  localparam int unsigned LatW = $clog2(CALC_LAT + 1);

  if (CALC_LAT < 1 || DEB_CYCLES < 1) begin : g_bad_params
    $error("calc_sequencer: CALC_LAT and DEB_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {StOff, StIdle, StExec, StNotify} state_e;

  // Bit order throughout: [0] mult, [1] sum, [2] sub, [3] on/off.
  logic [3:0] btn_raw;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] level;
  logic [3:0] prev_q;
  logic [3:0] event_q;
  logic [1:0] prime_q;
  logic       primed;

  assign btn_raw = {botao_4, botao_3, botao_2, botao_1};
  assign primed  = (prime_q == 2'd3);

  // Until the synchronizers have filled, edge history just tracks the level so a button
  // held across reset release never looks like a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      event_q <= '0;
      prime_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      if (!primed) begin
        prime_q <= prime_q + 2'd1;
        prev_q  <= sync2_q;
        event_q <= '0;
      end else begin
        prev_q  <= level;
        event_q <= level & ~prev_q;
      end
    end
  end

`ifdef CALC_DEBOUNCE_EN
  localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);

  logic [3:0]      level_q;
  logic [DebW-1:0] deb_cnt_q [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!primed) begin
          level_q[i]   <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else if (sync2_q[i] == level_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DebW'(DEB_CYCLES - 1)) begin
          level_q[i]   <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign level = level_q;
`else
  assign level = sync2_q;
`endif

  logic [2:0] op_sel;

  always_comb begin
    op_sel = 3'b000;
    if (event_q[0]) begin
      op_sel = 3'b001;
    end else if (event_q[1]) begin
      op_sel = 3'b010;
    end else if (event_q[2]) begin
      op_sel = 3'b100;
    end
  end

  state_e          state_q;
  logic [LatW-1:0] lat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StOff;
      lat_cnt_q        <= '0;
      power            <= 1'b0;
      busy             <= 1'b0;
      bus.sel          <= 3'b000;
      bus.op_a         <= '0;
      bus.op_b         <= '0;
      bus.op_sinal_a   <= 1'b0;
      bus.op_sinal_b   <= 1'b0;
      bus.result       <= '0;
      bus.result_sinal <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.lcd_req      <= 1'b0;
    end else if (event_q[3] && state_q != StOff) begin
      // Power-off wins from any active state; a pending LCD request is abandoned.
      state_q          <= StOff;
      power            <= 1'b0;
      busy             <= 1'b0;
      bus.sel          <= 3'b000;
      bus.result_valid <= 1'b0;
      bus.lcd_req      <= 1'b0;
    end else begin
      unique case (state_q)
        StOff: begin
          if (event_q[3]) begin
            state_q <= StIdle;
            power   <= 1'b1;
          end
        end
        StIdle: begin
          if (op_sel != 3'b000) begin
            state_q          <= StExec;
            busy             <= 1'b1;
            bus.sel          <= op_sel;
            bus.op_a         <= a;
            bus.op_b         <= b;
            bus.op_sinal_a   <= sinal_a;
            bus.op_sinal_b   <= sinal_b;
            bus.result_valid <= 1'b0;
            lat_cnt_q        <= LatW'(CALC_LAT);
          end
        end
        StExec: begin
          if (lat_cnt_q == LatW'(1)) begin
            state_q          <= StNotify;
            bus.result       <= bus.saida;
            bus.result_sinal <= bus.sinal_saida;
            bus.result_valid <= 1'b1;
            bus.lcd_req      <= 1'b1;
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end
        StNotify: begin
          if (bus.lcd_ack) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            bus.lcd_req <= 1'b0;
          end
        end
        default: state_q <= StOff;
      endcase
    end
  end

  a_sel_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.sel));
  a_req_valid:  assert property (@(posedge clk) disable iff (!rst_n)
                                 bus.lcd_req |-> bus.result_valid);
  a_busy_power: assert property (@(posedge clk) disable iff (!rst_n) busy |-> power);
  a_sel_power:  assert property (@(posedge clk) disable iff (!rst_n)
                                 (bus.sel != 3'b000) |-> power);

endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized self-checking bench for calc_sequencer with a behavioural calculator and
// reference model. Define CALC_DEBOUNCE_EN to exercise the debounce path (DEB_CYCLES = 4).
module tb_calc_sequencer;

  localparam int unsigned CLat = 2;
  localparam int unsigned Deb  = 4;
`ifdef CALC_DEBOUNCE_EN
  localparam int unsigned EvLat = 3 + Deb;
  localparam int unsigned Hold  = Deb + 1;
  localparam int unsigned Gap   = Deb + 4;
`else
  localparam int unsigned EvLat = 3;
  localparam int unsigned Hold  = 1;
  localparam int unsigned Gap   = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       sinal_a = 1'b0;
  logic       sinal_b = 1'b0;
  logic       botao_1 = 1'b0;
  logic       botao_2 = 1'b0;
  logic       botao_3 = 1'b0;
  logic       botao_4 = 1'b0;
  logic       power;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  calc_sequencer_if bus_if();

  calc_sequencer #(
    .DEB_CYCLES(Deb),
    .CALC_LAT  (CLat)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .sinal_a(sinal_a),
    .sinal_b(sinal_b),
    .botao_1(botao_1),
    .botao_2(botao_2),
    .botao_3(botao_3),
    .botao_4(botao_4),
    .power  (power),
    .busy   (busy),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  // Sign-magnitude arithmetic on signed integers; returns {sign, magnitude}.
  function automatic logic [16:0] calc(input logic [2:0] s, input logic [7:0] ma,
                                       input logic sa, input logic [7:0] mb, input logic sb);
    int va, vb, r;
    va = sa ? -int'(ma) : int'(ma);
    vb = sb ? -int'(mb) : int'(mb);
    case (s)
      3'b001:  r = va * vb;
      3'b010:  r = va + vb;
      3'b100:  r = va - vb;
      default: r = 0;
    endcase
    if (r < 0) return {1'b1, 16'(-r)};
    return {1'b0, 16'(r)};
  endfunction

  // Behavioural calculator with zero latency, fed from the latched operands.
  always_comb begin
    {bus_if.sinal_saida, bus_if.saida} = calc(bus_if.sel, bus_if.op_a, bus_if.op_sinal_a,
                                              bus_if.op_b, bus_if.op_sinal_b);
  end

  initial begin
    bus_if.lcd_ack = 1'b0;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0:       botao_1 = v;
      1:       botao_2 = v;
      2:       botao_3 = v;
      default: botao_4 = v;
    endcase
  endtask

  // Returns in the event cycle E of the press.
  task automatic press(input int idx);
    set_btn(idx, 1'b1);
    step(Hold);
    set_btn(idx, 1'b0);
    step(EvLat - Hold);
  endtask

  task automatic test_reset();
    logic [47:0] all_out;
    #2;
    all_out = {power, busy, bus_if.sel, bus_if.op_a, bus_if.op_b, bus_if.op_sinal_a,
               bus_if.op_sinal_b, bus_if.result, bus_if.result_sinal, bus_if.result_valid,
               bus_if.lcd_req};
    n_vec++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(5);
    n_vec++;
    if (power !== 1'b0) begin n_err++; $display("FAIL reset_off: power %b want 0", power); end
  endtask

  task automatic test_power();
    press(3);
    n_vec++;
    if (power !== 1'b0) begin n_err++; $display("FAIL power_early: got %b want 0", power); end
    step(1);
    n_vec++;
    if (power !== 1'b1) begin n_err++; $display("FAIL power_on: got %b want 1", power); end
    step(Gap);
    press(3);
    step(1);
    n_vec++;
    if ({power, bus_if.sel} !== 4'b0) begin
      n_err++; $display("FAIL power_off: power/sel %b want 0000", {power, bus_if.sel});
    end
    step(Gap);
    a = 8'd9; b = 8'd7;
    press(0);
    step(1);
    n_vec++;
    if ({power, busy, bus_if.sel} !== 5'b0) begin
      n_err++; $display("FAIL off_ignores_op: power/busy/sel %b want 0", {power, busy, bus_if.sel});
    end
    step(Gap);
    press(3);
    step(1 + Gap);
  endtask

  task automatic test_mult();
    a = 8'd5; sinal_a = 1'b0; b = 8'd3; sinal_b = 1'b1;
    press(0);
    step(1);
    n_vec++;
    if (bus_if.sel !== 3'b001 || busy !== 1'b1) begin
      n_err++; $display("FAIL mult_sel: sel %b busy %b want 001 1", bus_if.sel, busy);
    end
    n_vec++;
    if ({bus_if.op_sinal_a, bus_if.op_a, bus_if.op_sinal_b, bus_if.op_b} !== {1'b0, 8'd5, 1'b1, 8'd3})
    begin
      n_err++; $display("FAIL mult_ops: a %0d b %0d sb %b", bus_if.op_a, bus_if.op_b,
                        bus_if.op_sinal_b);
    end
    step(CLat - 1);
    n_vec++;
    if (bus_if.lcd_req !== 1'b0) begin n_err++; $display("FAIL mult_req_early: got 1 want 0"); end
    step(1);
    n_vec++;
    if ({bus_if.result_sinal, bus_if.result, bus_if.result_valid, bus_if.lcd_req} !==
        {1'b1, 16'd15, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL mult_result: sign %b mag %0d valid %b req %b want 1 15 1 1",
                        bus_if.result_sinal, bus_if.result, bus_if.result_valid, bus_if.lcd_req);
    end
    step(3);
    n_vec++;
    if (bus_if.lcd_req !== 1'b1) begin n_err++; $display("FAIL mult_req_hold: got 0 want 1"); end
    bus_if.lcd_ack = 1'b1;
    step(1);
    bus_if.lcd_ack = 1'b0;
    n_vec++;
    if ({bus_if.lcd_req, busy} !== 2'b00) begin
      n_err++; $display("FAIL mult_ack: req/busy %b want 00", {bus_if.lcd_req, busy});
    end
    step(Gap);
  endtask

  task automatic test_priority();
    logic [16:0] exp_res;
    a = 8'($urandom); b = 8'($urandom); sinal_a = 1'($urandom); sinal_b = 1'($urandom);
    exp_res = calc(3'b010, a, sinal_a, b, sinal_b);
    botao_2 = 1'b1; botao_3 = 1'b1;
    step(Hold);
    botao_2 = 1'b0; botao_3 = 1'b0;
    step(EvLat - Hold + 1);
    n_vec++;
    if (bus_if.sel !== 3'b010) begin
      n_err++; $display("FAIL prio_sel: got %b want 010", bus_if.sel);
    end
    step(CLat);
    n_vec++;
    if ({bus_if.result_sinal, bus_if.result} !== exp_res || bus_if.lcd_req !== 1'b1) begin
      n_err++; $display("FAIL prio_result: got %h req %b want %h 1",
                        {bus_if.result_sinal, bus_if.result}, bus_if.lcd_req, exp_res);
    end
    step(Gap);
    press(2);
    step(2);
    n_vec++;
    if ({bus_if.sel, busy, bus_if.lcd_req} !== 5'b01011) begin
      n_err++; $display("FAIL notify_drop: sel/busy/req %b want 01011",
                        {bus_if.sel, busy, bus_if.lcd_req});
    end
    bus_if.lcd_ack = 1'b1;
    step(1);
    bus_if.lcd_ack = 1'b0;
    step(EvLat + 2);
    n_vec++;
    if ({bus_if.sel, busy} !== 4'b0100) begin
      n_err++; $display("FAIL not_queued: sel/busy %b want 0100", {bus_if.sel, busy});
    end
    step(Gap);
  endtask

  task automatic test_off_in_exec();
    a = 8'($urandom); b = 8'($urandom);
    botao_1 = 1'b1;
    step(1);
    botao_4 = 1'b1;
    step(Hold - 1);
    botao_1 = 1'b0;
    step(1);
    botao_4 = 1'b0;
    step(EvLat + 2 - (Hold + 1));
    n_vec++;
    if ({power, busy, bus_if.sel, bus_if.result_valid, bus_if.lcd_req} !== 7'b0) begin
      n_err++; $display("FAIL off_in_exec: pwr/busy/sel/valid/req %b want 0",
                        {power, busy, bus_if.sel, bus_if.result_valid, bus_if.lcd_req});
    end
    for (int i = 0; i < 6; i++) begin
      step(1);
      n_vec++;
      if (bus_if.lcd_req !== 1'b0) begin
        n_err++; $display("FAIL off_no_req: cycle %0d req 1 want 0", i);
      end
    end
    step(Gap);
    press(3);
    step(1 + Gap);
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      int op, d;
      logic [2:0]  exp_sel;
      logic [16:0] exp_res;
      logic [17:0] exp_ops;
      op = int'($urandom_range(0, 2));
      d  = int'($urandom_range(0, 3));
      a = 8'($urandom); b = 8'($urandom); sinal_a = 1'($urandom); sinal_b = 1'($urandom);
      exp_sel = 3'(1 << op);
      exp_res = calc(exp_sel, a, sinal_a, b, sinal_b);
      exp_ops = {sinal_a, a, sinal_b, b};
      press(op);
      step(1);
      n_vec++;
      if (bus_if.sel !== exp_sel || busy !== 1'b1 ||
          {bus_if.op_sinal_a, bus_if.op_a, bus_if.op_sinal_b, bus_if.op_b} !== exp_ops) begin
        n_err++; $display("FAIL rand_issue[%0d]: sel %b busy %b ops %h want %b 1 %h", it,
                          bus_if.sel, busy,
                          {bus_if.op_sinal_a, bus_if.op_a, bus_if.op_sinal_b, bus_if.op_b},
                          exp_sel, exp_ops);
      end
      a = 8'($urandom); b = 8'($urandom); sinal_a = 1'($urandom); sinal_b = 1'($urandom);
      step(CLat - 1);
      if (d == 0) bus_if.lcd_ack = 1'b1;
      step(1);
      n_vec++;
      if ({bus_if.result_sinal, bus_if.result} !== exp_res ||
          {bus_if.result_valid, bus_if.lcd_req} !== 2'b11) begin
        n_err++; $display("FAIL rand_result[%0d]: got %h valid %b req %b want %h 1 1", it,
                          {bus_if.result_sinal, bus_if.result}, bus_if.result_valid,
                          bus_if.lcd_req, exp_res);
      end
      for (int k = 1; k < d; k++) begin
        step(1);
        n_vec++;
        if (bus_if.lcd_req !== 1'b1) begin
          n_err++; $display("FAIL rand_req_hold[%0d]: got 0 want 1", it);
        end
      end
      bus_if.lcd_ack = 1'b1;
      step(1);
      bus_if.lcd_ack = 1'b0;
      n_vec++;
      if ({bus_if.lcd_req, busy, power} !== 3'b001) begin
        n_err++; $display("FAIL rand_ack[%0d]: req/busy/pwr %b want 001", it,
                          {bus_if.lcd_req, busy, power});
      end
      step(Gap);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_res;
    a = 8'($urandom); b = 8'($urandom); sinal_a = 1'($urandom); sinal_b = 1'($urandom);
    press(0);
    step(1 + CLat);
    a = 8'($urandom); b = 8'($urandom); sinal_a = 1'($urandom); sinal_b = 1'($urandom);
    exp_res = calc(3'b010, a, sinal_a, b, sinal_b);
    botao_2 = 1'b1;
    // Time the second event to land on the first IDLE cycle after the ack.
    for (int i = 1; i <= int'(EvLat); i++) begin
      step(1);
      if (i == int'(Hold)) botao_2 = 1'b0;
      if (i == int'(EvLat) - 1) bus_if.lcd_ack = 1'b1;
      if (i == int'(EvLat)) bus_if.lcd_ack = 1'b0;
    end
    n_vec++;
    if ({bus_if.lcd_req, busy} !== 2'b00) begin
      n_err++; $display("FAIL b2b_idle: req/busy %b want 00", {bus_if.lcd_req, busy});
    end
    step(1);
    n_vec++;
    if (bus_if.sel !== 3'b010 || busy !== 1'b1) begin
      n_err++; $display("FAIL b2b_accept: sel %b busy %b want 010 1", bus_if.sel, busy);
    end
    step(CLat);
    n_vec++;
    if ({bus_if.result_sinal, bus_if.result} !== exp_res || bus_if.lcd_req !== 1'b1) begin
      n_err++; $display("FAIL b2b_result: got %h req %b want %h 1",
                        {bus_if.result_sinal, bus_if.result}, bus_if.lcd_req, exp_res);
    end
    bus_if.lcd_ack = 1'b1;
    step(1);
    bus_if.lcd_ack = 1'b0;
    step(Gap);
  endtask

`ifdef CALC_DEBOUNCE_EN
  task automatic test_debounce();
    int seen;
    botao_2 = 1'b1;
    step(3);
    botao_2 = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (busy) seen++;
    end
    n_vec++;
    if (seen != 0) begin n_err++; $display("FAIL deb_glitch: busy %0d cycles want 0", seen); end
    botao_2 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (i == 7) begin
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL deb_early: busy 1 want 0"); end
      end
      if (i == 8) begin
        n_vec++;
        if (busy !== 1'b1 || bus_if.sel !== 3'b010) begin
          n_err++; $display("FAIL deb_event: busy %b sel %b want 1 010", busy, bus_if.sel);
        end
      end
    end
    botao_2 = 1'b0;
    n_vec++;
    if (bus_if.lcd_req !== 1'b1) begin n_err++; $display("FAIL deb_req: got 0 want 1"); end
    bus_if.lcd_ack = 1'b1;
    step(1);
    bus_if.lcd_ack = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (busy) seen++;
    end
    n_vec++;
    if (seen != 0) begin n_err++; $display("FAIL deb_single: busy %0d cycles want 0", seen); end
  endtask
`endif

  task automatic test_reset_mid_notify();
    logic [47:0] all_out;
    a = 8'($urandom | 1); b = 8'($urandom | 1); sinal_a = 1'b0; sinal_b = 1'b0;
    press(1);
    step(1 + CLat);
    n_vec++;
    if (bus_if.lcd_req !== 1'b1) begin n_err++; $display("FAIL rstn_setup: req 0 want 1"); end
    #2;
    rst_n = 1'b0;
    #1;
    all_out = {power, busy, bus_if.sel, bus_if.op_a, bus_if.op_b, bus_if.op_sinal_a,
               bus_if.op_sinal_b, bus_if.result, bus_if.result_sinal, bus_if.result_valid,
               bus_if.lcd_req};
    n_vec++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL reset_mid_notify: got %h want 0", all_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(5);
    n_vec++;
    if ({power, bus_if.lcd_req} !== 2'b00) begin
      n_err++; $display("FAIL post_reset: pwr/req %b want 00", {power, bus_if.lcd_req});
    end
  endtask

  initial begin
    test_reset();
    test_power();
    test_mult();
    test_priority();
    test_off_in_exec();
    test_random();
    test_back_to_back();
`ifdef CALC_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_mid_notify();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

endmodule
